uart_rx_frontend: RTL and testbench

Oversampling UART receiver that turns the raw `rx_signal` pin into bytes on a `rx_data`/`rx_valid`/`rx_ready` handshake. It sits directly upstream of `uart_sr_input` and the echo path in the Basys3 UART link, replacing the receiver half of the existing `uart` wrapper. It adds start-bit validation, majority-vote sampling, framing/overrun detection and optional parity.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_frontend.sv | 140 ++++++++++++++
 tb/tb_uart_rx_frontend.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type, oversampling default and baud divider helper.
package uart_pkg;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    // Clocks per oversample tick, never below 1 so slow clocks still tick every cycle.
    function automatic int uart_div(input int clk_freq, input int baud_rate, input int oversample);
        int d;
        d = clk_freq / (baud_rate * oversample);
        return (d < 1) ? 1 : d;
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: one-cycle tick every DIV clocks, phase cleared by clr, frozen while ena is low.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = uart_div(50_000_000, 115_200, OVERSAMPLE_DEFAULT)
) (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = ena && !clr && cnt == LAST;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (ena)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver with majority vote, framing/overrun detection
// and a single-entry holding register; UART_RX_PARITY_EN adds an even-parity bit.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  rx_signal,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  parity_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic                  sync1, sync2, tick, mid, vote;
    logic [1:0]            samp;
    logic [TW-1:0]         tcnt;
    logic [BW-1:0]         bcnt;
    logic [DATA_WIDTH-1:0] shreg;
`ifdef UART_RX_PARITY_EN
    logic                  par_bad;
`else
    assign parity_err = 1'b0;
`endif

    uart_baud_tick #(.DIV(uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE))) u_tick (
        .clk  (clk),
        .reset(reset),
        .ena  (ena),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // The decision tick is the third of the three mid-bit samples; the first two are already in samp.
    assign mid  = tick && tcnt == T_MID;
    assign vote = (samp[1] & samp[0]) | (samp[1] & sync2) | (samp[0] & sync2);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_signal;
            sync2 <= sync1;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            samp      <= 2'b11;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else if (ena) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (tick) begin
                samp <= {samp[0], sync2};
                tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
            end
            case (state)
                IDLE:
                    if (!sync2) begin
                        state <= START;
                        tcnt  <= '0;
                        bcnt  <= '0;
                    end
                START:
                    if (mid)
                        state <= vote ? IDLE : DATA;
                DATA:
                    if (mid) begin
                        shreg <= {vote, shreg[DATA_WIDTH-1:1]};
                        bcnt  <= (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
                        if (bcnt == B_LAST)
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
                PARITY:
                    if (mid) begin
                        par_bad <= vote != ^shreg;
                        state   <= STOP;
                    end
`endif
                STOP:
                    if (mid) begin
                        if (!vote) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else
                                overrun <= 1'b1;
                        end
                    end
                BREAK:
                    if (sync2)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: randomized and directed frames against a frame-level timing/handshake model.
module tb_uart_rx_frontend;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int BIT      = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    // Edge (counted from the edge after which the start bit is driven) at which the stop-bit outcome appears.
    localparam int LAT = 157 + BIT * NPAR;

    logic       clk = 0, reset = 1, ena = 1, rx_signal = 1, rx_ready = 0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, parity_err;

    uart_rx_frontend #(.DATA_WIDTH(8), .BAUD_RATE(BAUD), .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .rx_signal (rx_signal),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int ready_mode = 0, ready_pulse_at = -1;
    int ev_kind[int];
    logic [7:0] ev_data[int];
    logic m_valid = 0, m_old = 0, m_fe = 0, m_ov = 0, m_pe = 0;
    logic [7:0] m_data = 0;
    int obs_fe = 0, obs_ov = 0, obs_pe = 0, obs_vcyc = 0;
    logic [7:0] last_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Frame outcomes (1 good, 2 framing error, 3 parity error) keyed by the edge they take effect.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_data = 0; m_fe = 0; m_ov = 0; m_pe = 0;
            ev_kind.delete();
            ev_data.delete();
        end else begin
            cyc++;
            m_old = m_valid;
            m_valid = m_old && !rx_ready;
            m_fe = 0; m_ov = 0; m_pe = 0;
            if (ev_kind.exists(cyc)) begin
                if (ev_kind[cyc] == 2)
                    m_fe = 1;
                else begin
                    m_pe = (ev_kind[cyc] == 3);
                    if (m_old && !rx_ready)
                        m_ov = 1;
                    else begin
                        m_valid = 1;
                        m_data = ev_data[cyc];
                    end
                end
                ev_kind.delete(cyc);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rx_ready = (cyc + 1 == ready_pulse_at) ||
                   (ready_mode == 2 ? $urandom_range(0, 1) == 1 : ready_mode == 1);
    end

    always @(negedge clk)
        if (!reset) begin
            chk("rx_valid", int'(rx_valid), int'(m_valid));
            if (m_valid) chk("rx_data", int'(rx_data), int'(m_data));
            chk("frame_err", int'(frame_err), int'(m_fe));
            chk("overrun", int'(overrun), int'(m_ov));
            chk("parity_err", int'(parity_err), int'(m_pe));
            if (frame_err) obs_fe++;
            if (overrun) obs_ov++;
            if (parity_err) obs_pe++;
            if (rx_valid) begin
                obs_vcyc++;
                last_seen = rx_data;
            end
        end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx_signal = 1;
        step(n);
    endtask

    task automatic drive_bit(input logic b);
        rx_signal = b;
        step(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok, input int abort_bits);
        if (abort_bits < 0) begin
            ev_kind[cyc + LAT] = !stop ? 2 : (NPAR == 1 && !par_ok) ? 3 : 1;
            ev_data[cyc + LAT] = d;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (abort_bits == i + 1) begin
                rx_signal = 1;
                reset = 1;
                return;
            end
            drive_bit(d[i]);
        end
        if (NPAR == 1) drive_bit(^d ^ !par_ok);
        drive_bit(stop);
    endtask

    int b0, b1, b2;

    initial begin
        step(3);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_data", int'(rx_data), 0);
        chk("reset_errs", int'({frame_err, overrun, parity_err}), 0);
        reset = 0;
        idle(10);

        ready_mode = 1;
        b0 = obs_vcyc; b1 = obs_fe + obs_ov + obs_pe;
        send_frame(8'hA5, 1, 1, -1);
        idle(20);
        chk("a5_data", int'(last_seen), 8'hA5);
        chk("a5_valid_cycles", obs_vcyc - b0, 1);
        chk("a5_no_errors", obs_fe + obs_ov + obs_pe - b1, 0);

        ready_mode = 0;
        b0 = obs_ov;
        send_frame(8'h3C, 1, 1, -1);
        send_frame(8'hC3, 1, 1, -1);
        idle(5);
        chk("ovr_data_kept", int'(rx_data), 8'h3C);
        chk("ovr_valid", int'(rx_valid), 1);
        chk("ovr_pulses", obs_ov - b0, 1);
        ready_mode = 1;
        idle(5);

        ready_mode = 0;
        b0 = obs_ov;
        send_frame(8'h3C, 1, 1, -1);
        ready_pulse_at = cyc + LAT;
        send_frame(8'hC3, 1, 1, -1);
        idle(5);
        chk("xfer_data", int'(rx_data), 8'hC3);
        chk("xfer_valid", int'(rx_valid), 1);
        chk("xfer_no_ovr", obs_ov - b0, 0);
        ready_pulse_at = -1;
        ready_mode = 1;
        idle(5);

        b0 = obs_vcyc;
        rx_signal = 0;
        step(4);
        idle(40);
        chk("glitch_no_byte", obs_vcyc - b0, 0);
        chk("glitch_valid", int'(rx_valid), 0);

        b0 = obs_fe; b1 = obs_vcyc;
        send_frame(8'h55, 0, 1, -1);
        rx_signal = 0;
        step(40);
        idle(20);
        chk("break_ferr", obs_fe - b0, 1);
        chk("break_no_byte", obs_vcyc - b1, 0);
        send_frame(8'h12, 1, 1, -1);
        idle(20);
        chk("after_break_data", int'(last_seen), 8'h12);
        chk("after_break_bytes", obs_vcyc - b1, 1);

        send_frame(8'hFF, 1, 1, 4);
        @(negedge clk);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_data", int'(rx_data), 0);
        chk("rst_errs", int'({frame_err, overrun, parity_err}), 0);
        @(posedge clk);
        #1;
        reset = 0;
        idle(20);
        send_frame(8'h81, 1, 1, -1);
        idle(20);
        chk("post_rst_data", int'(last_seen), 8'h81);

`ifdef UART_RX_PARITY_EN
        b0 = obs_pe;
        send_frame(8'h07, 1, 0, -1);
        idle(20);
        chk("par_err_pulse", obs_pe - b0, 1);
        chk("par_err_data", int'(last_seen), 8'h07);
`endif

        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            b2 = $urandom_range(0, 7);
            send_frame(8'($urandom), b2 != 0, $urandom_range(0, 3) != 0, -1);
            if (b2 == 0) begin
                rx_signal = 0;
                step($urandom_range(0, 30));
                idle(40);
            end else
                idle(BIT * $urandom_range(0, 2));
        end
        ready_mode = 1;
        idle(60);
        chk("events_drained", ev_kind.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
